// File: rtl/text_mode_pkg.sv
// Shared geometry, derived widths and the sideband bundle for the text-mode
// pixel pipeline.
package text_mode_pkg;

  localparam int COLS    = 80;
  localparam int ROWS    = 30;
  localparam int CHAR_W  = 8;
  localparam int CHAR_H  = 16;
  localparam int PIXEL_W = 11;

  localparam int TEXT_ADDR_W = $clog2(COLS * ROWS);
  localparam int CELL_X_W    = $clog2(CHAR_W);
  localparam int CELL_Y_W    = $clog2(CHAR_H);
  localparam int COL_W       = PIXEL_W - CELL_X_W;
  localparam int ROW_W       = PIXEL_W - CELL_Y_W;

  localparam int PIPE_LATENCY = 4;

  // Per-pixel control travelling alongside the text/font fetch.
  typedef struct packed {
    logic in_range;
    logic cursor_hit;
    logic active;
    logic hsync;
    logic vsync;
  } sideband_t;

endpackage

// File: rtl/cursor_blink_timer.sv
// Cursor blink timer: counts frame_start pulses and toggles blink_phase
// every BLINK_FRAMES frames. Only compiled when CURSOR_BLINK_EN is defined.
`ifdef CURSOR_BLINK_EN
module cursor_blink_timer
  import text_mode_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic CLOCK_150,
  input  logic RESET,
  input  logic frame_start,
  output logic blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt;

  // Frame counter wraps at BLINK_FRAMES-1 and flips the phase on the wrap.
  always_ff @(posedge CLOCK_150 or posedge RESET) begin
    if (RESET) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/text_mode_renderer.sv
// Text-mode renderer: four-stage pixel pipeline between the VGA timing
// generator, the text buffer RAM and the font ROM, with a hardware cursor.
// Optional macro CURSOR_BLINK_EN adds a frame-based cursor blink; without it
// the cursor is a solid inverse block and frame_start is ignored.
module text_mode_renderer #(
  parameter int COLS         = text_mode_pkg::COLS,
  parameter int ROWS         = text_mode_pkg::ROWS,
  parameter int CHAR_W       = text_mode_pkg::CHAR_W,
  parameter int CHAR_H       = text_mode_pkg::CHAR_H,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                          CLOCK_150,
  input  logic                          RESET,
  input  logic [10:0]                   pixel_x,
  input  logic [10:0]                   pixel_y,
  input  logic                          in_active,
  input  logic                          in_hsync,
  input  logic                          in_vsync,
  input  logic                          frame_start,
  output logic [$clog2(COLS*ROWS)-1:0]  text_addr,
  input  logic [7:0]                    text_data,
  output logic [7:0]                    font_character,
  output logic [$clog2(CHAR_W)-1:0]     font_cell_x,
  output logic [$clog2(CHAR_H)-1:0]     font_cell_y,
  input  logic                          font_pixel,
  input  logic [6:0]                    cursor_col,
  input  logic [4:0]                    cursor_row,
  input  logic                          cursor_enable,
  output logic                          pixel_on,
  output logic                          out_active,
  output logic                          out_hsync,
  output logic                          out_vsync
);
  import text_mode_pkg::*;

  localparam int ADDR_W = $clog2(COLS * ROWS);
  localparam int CX_W   = $clog2(CHAR_W);
  localparam int CY_W   = $clog2(CHAR_H);
  localparam int C_W    = 11 - CX_W;
  localparam int R_W    = 11 - CY_W;

  logic [C_W-1:0]    col;
  logic [R_W-1:0]    row;
  logic [CX_W-1:0]   cell_x;
  logic [CY_W-1:0]   cell_y;
  logic              in_range;
  logic              cursor_match;
  logic              blink_gate;
  logic [ADDR_W-1:0] addr_calc;
  sideband_t         sb_in;

  logic [CX_W-1:0]   s1_cell_x;
  logic [CY_W-1:0]   s1_cell_y;
  sideband_t         s1_sb;
  sideband_t         s2_sb;
  sideband_t         s3_sb;

  // Glyph sizes are powers of two, so cell index and offset are bit fields.
  assign col    = pixel_x[10:CX_W];
  assign row    = pixel_y[10:CY_W];
  assign cell_x = pixel_x[CX_W-1:0];
  assign cell_y = pixel_y[CY_W-1:0];

  assign in_range     = in_active && (int'(col) < COLS) && (int'(row) < ROWS);
  assign cursor_match = (col == C_W'(cursor_col)) && (row == R_W'(cursor_row));
  assign addr_calc    = ADDR_W'(int'(row) * COLS + int'(col));

  assign sb_in = '{in_range:   in_range,
                   cursor_hit: cursor_enable && cursor_match && blink_gate,
                   active:     in_active,
                   hsync:      in_hsync,
                   vsync:      in_vsync};

`ifdef CURSOR_BLINK_EN
  logic blink_phase;

  cursor_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .CLOCK_150  (CLOCK_150),
    .RESET      (RESET),
    .frame_start(frame_start),
    .blink_phase(blink_phase)
  );

  assign blink_gate = blink_phase;
`else
  // Without the timer the frame pulse and blink period have no effect.
  logic unused_blink_cfg;
  assign unused_blink_cfg = frame_start | (BLINK_FRAMES < 1);
  assign blink_gate       = 1'b1;
`endif

  // Character code from the text RAM feeds the font ROM directly.
  assign font_character = text_data;

  // Stage 1: issue the text buffer address and capture cell offsets/sideband.
  always_ff @(posedge CLOCK_150 or posedge RESET) begin
    if (RESET) begin
      text_addr <= '0;
      s1_cell_x <= '0;
      s1_cell_y <= '0;
      s1_sb     <= '0;
    end else begin
      text_addr <= in_range ? addr_calc : '0;
      s1_cell_x <= cell_x;
      s1_cell_y <= cell_y;
      s1_sb     <= sb_in;
    end
  end

  // Stage 2: cell offsets line up with the character returned by the RAM.
  always_ff @(posedge CLOCK_150 or posedge RESET) begin
    if (RESET) begin
      font_cell_x <= '0;
      font_cell_y <= '0;
      s2_sb       <= '0;
    end else begin
      font_cell_x <= s1_cell_x;
      font_cell_y <= s1_cell_y;
      s2_sb       <= s1_sb;
    end
  end

  // Stage 3: sideband waits while the font ROM registers its pixel bit.
  always_ff @(posedge CLOCK_150 or posedge RESET) begin
    if (RESET) begin
      s3_sb <= '0;
    end else begin
      s3_sb <= s2_sb;
    end
  end

  // Stage 4: combine glyph bit with cursor inversion and register outputs.
  always_ff @(posedge CLOCK_150 or posedge RESET) begin
    if (RESET) begin
      pixel_on   <= 1'b0;
      out_active <= 1'b0;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
    end else begin
      pixel_on   <= s3_sb.in_range & (font_pixel ^ s3_sb.cursor_hit);
      out_active <= s3_sb.active;
      out_hsync  <= s3_sb.hsync;
      out_vsync  <= s3_sb.vsync;
    end
  end

endmodule

// File: tb/tb_text_mode_renderer.sv
// Directed testbench for text_mode_renderer with behavioural text RAM
// (mem[a] = a[7:0]) and font ROM (bit = char[cell_x] ^ cell_y[0]).
`timescale 1ns/1ps
module tb_text_mode_renderer;
  import text_mode_pkg::*;

  logic                   CLOCK_150 = 1'b0;
  logic                   RESET;
  logic [10:0]            pixel_x, pixel_y;
  logic                   in_active, in_hsync, in_vsync, frame_start;
  logic [TEXT_ADDR_W-1:0] text_addr;
  logic [7:0]             text_data, font_character;
  logic [CELL_X_W-1:0]    font_cell_x;
  logic [CELL_Y_W-1:0]    font_cell_y;
  logic                   font_pixel;
  logic [6:0]             cursor_col;
  logic [4:0]             cursor_row;
  logic                   cursor_enable;
  logic                   pixel_on, out_active, out_hsync, out_vsync;

  int tests = 0;
  int fails = 0;

  logic [7:0] text_mem [0:COLS*ROWS-1];

  always #5 CLOCK_150 = ~CLOCK_150;

  text_mode_renderer #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .BLINK_FRAMES(30)
  ) dut (
    .CLOCK_150(CLOCK_150), .RESET(RESET), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .in_active(in_active), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .frame_start(frame_start), .text_addr(text_addr), .text_data(text_data),
    .font_character(font_character), .font_cell_x(font_cell_x),
    .font_cell_y(font_cell_y), .font_pixel(font_pixel), .cursor_col(cursor_col),
    .cursor_row(cursor_row), .cursor_enable(cursor_enable), .pixel_on(pixel_on),
    .out_active(out_active), .out_hsync(out_hsync), .out_vsync(out_vsync)
  );

  // Registered text RAM and font ROM models
  always @(posedge CLOCK_150) text_data <= text_mem[text_addr];
  always @(posedge CLOCK_150) font_pixel <= font_character[font_cell_x] ^ font_cell_y[0];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_idle();
    pixel_x = '0; pixel_y = '0; in_active = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
  endtask

  // Drive one pixel, then idle; capture the stage outputs belonging to it.
  task automatic probe(input logic [10:0] x, input logic [10:0] y, input logic act,
                       output logic [TEXT_ADDR_W-1:0] addr, output logic [CELL_X_W-1:0] cx,
                       output logic [CELL_Y_W-1:0] cy, output logic [7:0] ch,
                       output logic pix, output logic oact);
    @(negedge CLOCK_150); pixel_x = x; pixel_y = y; in_active = act;
    @(negedge CLOCK_150); addr = text_addr; set_idle();
    @(negedge CLOCK_150); cx = font_cell_x; cy = font_cell_y; ch = font_character;
    @(negedge CLOCK_150);
    @(negedge CLOCK_150); pix = pixel_on; oact = out_active;
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_150); frame_start = 1'b1;
      @(negedge CLOCK_150); frame_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; set_idle(); frame_start = 1'b0;
    cursor_col = '0; cursor_row = '0; cursor_enable = 1'b0;
    for (int i = 0; i < COLS*ROWS; i++) text_mem[i] = 8'(i);
    repeat (3) @(negedge CLOCK_150);
    tests++; if (text_addr !== '0) begin fails++; $display("FAIL reset_text_addr: got %0d expected 0", text_addr); end
    tests++; if (font_cell_x !== '0) begin fails++; $display("FAIL reset_cell_x: got %0d expected 0", font_cell_x); end
    tests++; if (font_cell_y !== '0) begin fails++; $display("FAIL reset_cell_y: got %0d expected 0", font_cell_y); end
    tests++; if (pixel_on !== 1'b0) begin fails++; $display("FAIL reset_pixel_on: got %b expected 0", pixel_on); end
    tests++; if ({out_active, out_hsync, out_vsync} !== 3'b000) begin fails++; $display("FAIL reset_sync: got %b expected 000", {out_active, out_hsync, out_vsync}); end
    RESET = 1'b0;
  endtask

  task automatic test_address();
    logic [TEXT_ADDR_W-1:0] a; logic [CELL_X_W-1:0] cx; logic [CELL_Y_W-1:0] cy;
    logic [7:0] ch; logic p, oa;
    probe(11'd17, 11'd35, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (a !== 162) begin fails++; $display("FAIL addr_17_35: got %0d expected 162", a); end
    tests++; if (cx !== 1) begin fails++; $display("FAIL cell_x_17: got %0d expected 1", cx); end
    tests++; if (cy !== 3) begin fails++; $display("FAIL cell_y_35: got %0d expected 3", cy); end
    tests++; if (ch !== 8'hA2) begin fails++; $display("FAIL font_char_162: got %h expected a2", ch); end
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL pixel_17_35: got %b expected 0", p); end
    tests++; if (oa !== 1'b1) begin fails++; $display("FAIL active_17_35: got %b expected 1", oa); end
  endtask

  task automatic test_latency();
    for (int k = 0; k <= 20; k++) begin
      @(negedge CLOCK_150);
      if (k >= 4) begin
        tests++; if (out_hsync !== (k == 14)) begin fails++; $display("FAIL lat_hsync k=%0d: got %b expected %b", k, out_hsync, (k == 14)); end
        tests++; if (pixel_on !== (k == 14)) begin fails++; $display("FAIL lat_pixel k=%0d: got %b expected %b", k, pixel_on, (k == 14)); end
        tests++; if (out_active !== (k == 14)) begin fails++; $display("FAIL lat_active k=%0d: got %b expected %b", k, out_active, (k == 14)); end
      end
      if (k == 10) begin
        pixel_x = 11'd16; pixel_y = 11'd35; in_active = 1'b1; in_hsync = 1'b1;
      end else begin
        set_idle();
      end
    end
  endtask

  task automatic test_back_to_back();
    // Glyph 0xA2 on an odd cell row, cell_x 0..7
    logic [7:0] exp_seq;
    exp_seq = 8'b0101_1101;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLOCK_150);
      if (k >= 1 && k <= 8) begin
        tests++; if (text_addr !== 162) begin fails++; $display("FAIL b2b_addr k=%0d: got %0d expected 162", k, text_addr); end
      end
      if (k >= 4) begin
        tests++; if (pixel_on !== exp_seq[k-4]) begin fails++; $display("FAIL b2b_pixel k=%0d: got %b expected %b", k, pixel_on, exp_seq[k-4]); end
      end
      if (k < 8) begin
        pixel_x = 11'(16 + k); pixel_y = 11'd35; in_active = 1'b1;
      end else begin
        set_idle();
      end
    end
  endtask

  task automatic test_boundaries();
    logic [TEXT_ADDR_W-1:0] a; logic [CELL_X_W-1:0] cx; logic [CELL_Y_W-1:0] cy;
    logic [7:0] ch; logic p, oa;
    probe(11'd640, 11'd35, 1'b0, a, cx, cy, ch, p, oa);
    tests++; if (a !== 0) begin fails++; $display("FAIL inactive_addr: got %0d expected 0", a); end
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL inactive_pixel: got %b expected 0", p); end
    tests++; if (oa !== 1'b0) begin fails++; $display("FAIL inactive_active: got %b expected 0", oa); end
    probe(11'd640, 11'd35, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (a !== 0) begin fails++; $display("FAIL col80_addr: got %0d expected 0", a); end
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL col80_pixel: got %b expected 0", p); end
    tests++; if (oa !== 1'b1) begin fails++; $display("FAIL col80_active: got %b expected 1", oa); end
    probe(11'd0, 11'd481, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (a !== 0) begin fails++; $display("FAIL row30_addr: got %0d expected 0", a); end
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL row30_pixel: got %b expected 0", p); end
    probe(11'd0, 11'd479, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (a !== 2320) begin fails++; $display("FAIL row29_addr: got %0d expected 2320", a); end
    tests++; if (ch !== 8'h10) begin fails++; $display("FAIL row29_char: got %h expected 10", ch); end
    tests++; if (cy !== 15) begin fails++; $display("FAIL row29_cell_y: got %0d expected 15", cy); end
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL row29_pixel: got %b expected 1", p); end
    probe(11'd639, 11'd479, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (a !== 2399) begin fails++; $display("FAIL last_addr: got %0d expected 2399", a); end
    tests++; if (ch !== 8'h5F) begin fails++; $display("FAIL last_char: got %h expected 5f", ch); end
    tests++; if (cx !== 7) begin fails++; $display("FAIL last_cell_x: got %0d expected 7", cx); end
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL last_pixel: got %b expected 1", p); end
    probe(11'd638, 11'd479, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL x638_pixel: got %b expected 0", p); end
  endtask

`ifdef CURSOR_BLINK_EN
  task automatic test_blink();
    logic [TEXT_ADDR_W-1:0] a; logic [CELL_X_W-1:0] cx; logic [CELL_Y_W-1:0] cy;
    logic [7:0] ch; logic p, oa;
    cursor_col = 7'd2; cursor_row = 5'd2; cursor_enable = 1'b1;
    probe(11'd17, 11'd35, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL blink_phase0: got %b expected 0", p); end
    pulse_frames(29);
    probe(11'd17, 11'd35, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL blink_29: got %b expected 0", p); end
    pulse_frames(1);
    probe(11'd17, 11'd35, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL blink_30: got %b expected 1", p); end
    pulse_frames(30);
    probe(11'd17, 11'd35, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL blink_60: got %b expected 0", p); end
    pulse_frames(30);
    probe(11'd17, 11'd35, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL blink_90: got %b expected 1", p); end
    cursor_enable = 1'b0;
  endtask
`endif

  task automatic test_cursor();
    logic [TEXT_ADDR_W-1:0] a; logic [CELL_X_W-1:0] cx; logic [CELL_Y_W-1:0] cy;
    logic [7:0] ch; logic p, oa;
    cursor_col = 7'd2; cursor_row = 5'd2; cursor_enable = 1'b1;
    probe(11'd17, 11'd35, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL cursor_on_glyph0: got %b expected 1", p); end
    probe(11'd16, 11'd35, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL cursor_on_glyph1: got %b expected 0", p); end
    probe(11'd25, 11'd35, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL cursor_next_col: got %b expected 0", p); end
    probe(11'd17, 11'd51, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL cursor_next_row: got %b expected 0", p); end
    cursor_col = 7'd3;
    probe(11'd25, 11'd35, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL cursor_moved: got %b expected 1", p); end
    cursor_col = 7'd2; cursor_enable = 1'b0;
    probe(11'd17, 11'd35, 1'b1, a, cx, cy, ch, p, oa);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL cursor_disabled: got %b expected 0", p); end
  endtask

  task automatic test_reset_midstream();
    @(negedge CLOCK_150);
    pixel_x = 11'd18; pixel_y = 11'd35; in_active = 1'b1; in_hsync = 1'b1; in_vsync = 1'b1;
    repeat (5) @(negedge CLOCK_150);
    tests++; if (pixel_on !== 1'b1) begin fails++; $display("FAIL pre_reset_pixel: got %b expected 1", pixel_on); end
    tests++; if (text_addr !== 162) begin fails++; $display("FAIL pre_reset_addr: got %0d expected 162", text_addr); end
    #2 RESET = 1'b1;
    #1;
    tests++; if (pixel_on !== 1'b0) begin fails++; $display("FAIL async_reset_pixel: got %b expected 0", pixel_on); end
    tests++; if ({out_active, out_hsync, out_vsync} !== 3'b000) begin fails++; $display("FAIL async_reset_sync: got %b expected 000", {out_active, out_hsync, out_vsync}); end
    tests++; if (text_addr !== '0) begin fails++; $display("FAIL async_reset_addr: got %0d expected 0", text_addr); end
    tests++; if ({font_cell_x, font_cell_y} !== '0) begin fails++; $display("FAIL async_reset_cells: got %0d/%0d expected 0/0", font_cell_x, font_cell_y); end
    @(negedge CLOCK_150); RESET = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge CLOCK_150);
      tests++; if (pixel_on !== (n == 4)) begin fails++; $display("FAIL restart_pixel n=%0d: got %b expected %b", n, pixel_on, (n == 4)); end
      tests++; if (out_hsync !== (n == 4)) begin fails++; $display("FAIL restart_hsync n=%0d: got %b expected %b", n, out_hsync, (n == 4)); end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_address();
    test_latency();
    test_back_to_back();
    test_boundaries();
`ifdef CURSOR_BLINK_EN
    test_blink();
`endif
    test_cursor();
    test_reset_midstream();
    repeat (2) @(negedge CLOCK_150);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
